pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB). Consumes the hazard stall request, EX-stage branch resolution, the data-memory busy handshake and the ID-stage HLT decode. Produces every PC and pipeline-register write enable and clear, per-stage valid bits, the halted status and saturating performance counters. Sits beside the hazard detector in the CPU top level.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam int unsigned DRAIN_CYC_DEF = 3;
    localparam int unsigned CNT_W_DEF     = 16;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: stage enables/clears, valid
// tracking, HLT drain-to-halt and saturating performance counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             halt_id,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned DC_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    ctrl_state_t   state_q, state_d;
    logic [DC_W-1:0] drain_q, drain_d;
    logic          v_id_q, v_ex_q, v_mem_q, v_wb_q;
    logic          v_id_d, v_ex_d, v_mem_d, v_wb_d;
    logic          halted_q, halted_d;
    logic          shift, kill_id, kill_ex;
    logic          stall_inc, flush_inc, retire_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            drain_q  <= '0;
            v_id_q   <= 1'b0;
            v_ex_q   <= 1'b0;
            v_mem_q  <= 1'b0;
            v_wb_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            v_id_q   <= v_id_d;
            v_ex_q   <= v_ex_d;
            v_mem_q  <= v_mem_d;
            v_wb_q   <= v_wb_d;
            halted_q <= halted_d;
        end
    end

    // Priority: rst > mem_busy > branch > halt > hazard; DRAIN/HALTED ignore the latter three.
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        halted_d      = halted_q;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_we     = 1'b0;
        if_id_clr     = 1'b0;
        id_ex_clr     = 1'b0;
        shift         = 1'b0;
        kill_id       = 1'b0;
        kill_ex       = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (rst) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else if (branch_taken) begin
                        pc_we         = 1'b1;
                        pc_sel_branch = 1'b1;
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_clr     = 1'b1;
                        id_ex_clr     = 1'b1;
                        shift         = 1'b1;
                        kill_id       = 1'b1;
                        kill_ex       = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (halt_id && v_id_q) begin
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_clr = 1'b1;
                        shift     = 1'b1;
                        kill_id   = 1'b1;
                        state_d   = DRAIN;
                        drain_d   = DC_W'(DRAIN_CYC);
                    end else if (hazard) begin
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_clr = 1'b1;
                        shift     = 1'b1;
                        kill_id   = 1'b1;
                        stall_inc = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        shift = 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else begin
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_clr = 1'b1;
                        shift     = 1'b1;
                        kill_id   = 1'b1;
                        drain_d   = drain_q - DC_W'(1);
                        if (drain_q == DC_W'(1)) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted_d = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Stage valid bits follow the instruction stream only when the pipe advances.
    always_comb begin
        v_id_d  = v_id_q;
        v_ex_d  = v_ex_q;
        v_mem_d = v_mem_q;
        v_wb_d  = v_wb_q;
        if (shift) begin
            v_id_d  = ~kill_id;
            v_ex_d  = v_id_q & ~kill_ex;
            v_mem_d = v_ex_q;
            v_wb_d  = v_mem_q;
        end
    end

    assign retire_inc = v_wb_q & mem_wb_we;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_inc),
        .count (retire_cnt)
    );

    assign v_id   = v_id_q;
    assign v_ex   = v_ex_q;
    assign v_mem  = v_mem_q;
    assign v_wb   = v_wb_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle event-table model plus literal
// spot checks for the headline scenarios.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int          DRAIN = 3;
    localparam int          CMAX  = 15;

    localparam int EV_RST = 0, EV_HOLD = 1, EV_FRZ = 2, EV_DRN = 3;
    localparam int EV_BR  = 4, EV_HLT  = 5, EV_HAZ = 6, EV_RUN = 7;
    localparam int M_RUN  = 0, M_DRAIN = 1, M_HALT = 2;

    logic clk = 1'b0;
    logic rst, hazard, branch_taken, halt_id, mem_busy;
    logic pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_clr, id_ex_clr, v_id, v_ex, v_mem, v_wb, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;
    logic [7:0] en_vec;

    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .halt_id       (halt_id),
        .mem_busy      (mem_busy),
        .pc_we         (pc_we),
        .pc_sel_branch (pc_sel_branch),
        .if_id_we      (if_id_we),
        .id_ex_we      (id_ex_we),
        .ex_mem_we     (ex_mem_we),
        .mem_wb_we     (mem_wb_we),
        .if_id_clr     (if_id_clr),
        .id_ex_clr     (id_ex_clr),
        .v_id          (v_id),
        .v_ex          (v_ex),
        .v_mem         (v_mem),
        .v_wb          (v_wb),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    assign en_vec = {pc_we, pc_sel_branch, if_id_we, id_ex_we,
                     ex_mem_we, mem_wb_we, if_id_clr, id_ex_clr};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: valid bits {wb,mem,ex,id}, mode, drain cycles left, counters.
    logic [3:0] m_v      = 4'b0000;
    int         m_mode   = M_RUN;
    int         m_drain  = 0;
    logic       m_halted = 1'b0;
    int         m_stall  = 0;
    int         m_flush  = 0;
    int         m_retire = 0;
    logic       chk_en   = 1'b0;
    int         ev;
    logic [7:0] ex_en;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst)                            ev = EV_RST;
            else if (m_mode == M_HALT)          ev = EV_HOLD;
            else if (mem_busy)                  ev = EV_FRZ;
            else if (m_mode == M_DRAIN)         ev = EV_DRN;
            else if (branch_taken)              ev = EV_BR;
            else if (halt_id && m_v[0])         ev = EV_HLT;
            else if (hazard)                    ev = EV_HAZ;
            else                                ev = EV_RUN;

            // {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_clr, id_ex_clr}
            case (ev)
                EV_RST:                  ex_en = 8'b0000_0011;
                EV_BR:                   ex_en = 8'b1111_1111;
                EV_RUN:                  ex_en = 8'b1011_1100;
                EV_HLT, EV_HAZ, EV_DRN:  ex_en = 8'b0011_1110;
                default:                 ex_en = 8'b0000_0000;
            endcase

            chk("enables", 32'(en_vec), 32'(ex_en));
            chk("valid",   32'({v_wb, v_mem, v_ex, v_id}), 32'(m_v));
            chk("halted",  32'(halted), 32'(m_halted));
            chk("stall_cnt",  32'(stall_cnt),  32'(m_stall));
            chk("flush_cnt",  32'(flush_cnt),  32'(m_flush));
            chk("retire_cnt", 32'(retire_cnt), 32'(m_retire));

            if (ev == EV_RST) begin
                m_v = 4'b0000; m_mode = M_RUN; m_drain = 0; m_halted = 1'b0;
                m_stall = 0; m_flush = 0; m_retire = 0;
            end else begin
                if (m_v[3] && ex_en[2] && m_retire < CMAX) m_retire++;
                if ((ev == EV_FRZ || ev == EV_HAZ) && m_stall < CMAX) m_stall++;
                if (ev == EV_BR && m_flush < CMAX) m_flush++;
                if (ev >= EV_DRN)
                    m_v = {m_v[2], m_v[1], (ev == EV_BR) ? 1'b0 : m_v[0], (ev == EV_RUN) ? 1'b1 : 1'b0};
                if (ev == EV_HLT) begin
                    m_mode = M_DRAIN; m_drain = DRAIN;
                end else if (ev == EV_DRN) begin
                    if (m_drain == 1) begin
                        m_mode = M_HALT; m_halted = 1'b1;
                    end
                    m_drain--;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic mb, input logic br, input logic hl, input logic hz);
        @(posedge clk);
        #1;
        rst = r; mem_busy = mb; branch_taken = br; halt_id = hl; hazard = hz;
        @(negedge clk);
    endtask

    int zeros;

    initial begin
        rst = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0; halt_id = 1'b0; hazard = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        chk_en = 1'b1;

        // Idle from reset: pipe fills, first retirement in cycle 4.
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 0) chk("A_en_first", 32'(en_vec), 32'h0000_00BC);
            if (c == 3) chk("A_vwb_c3", 32'(v_wb), 32'd0);
            if (c == 4) chk("A_vwb_c4", 32'(v_wb), 32'd1);
            if (c == 6) chk("A_retire", 32'(retire_cnt), 32'd2);
        end

        // Two-cycle hazard: two bubbles reach WB.
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("B_pc_we", 32'(pc_we), 32'd0);
            chk("B_if_id_clr", 32'(if_id_clr), 32'd1);
        end
        zeros = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 0) chk("B_stall", 32'(stall_cnt), 32'd2);
            if (!v_wb) zeros++;
        end
        chk("B_bubbles", 32'(zeros), 32'd2);

        // Branch beats a valid HLT; then freeze beats branch.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("C_en_branch", 32'(en_vec), 32'h0000_00FF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("C_flush", 32'(flush_cnt), 32'd1);
        chk("C_still_run", 32'(pc_we), 32'd1);
        chk("C_not_halted", 32'(halted), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("C_en_freeze", 32'(en_vec), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("C_en_branch2", 32'(en_vec), 32'h0000_00FF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("C_flush2", 32'(flush_cnt), 32'd2);
        chk("C_stall3", 32'(stall_cnt), 32'd3);

        // HLT at t, freeze at t+2: halted from t+5.
        for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("D_en_halt", 32'(en_vec), 32'h0000_003E);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("D_drain_pc_we", 32'(pc_we), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("D_en_freeze", 32'(en_vec), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("D_halted_t4", 32'(halted), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("D_halted_t5", 32'(halted), 32'd1);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'(c == 3), 1'(c == 2), 1'b0, 1'(c % 2 == 0));
            chk("D_en_halted", 32'(en_vec), 32'd0);
        end

        // Reset out of HALTED, then long hazard saturates stall_cnt.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("E_en_rst", 32'(en_vec), 32'h0000_0003);
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (c == 0)  chk("E_stall0", 32'(stall_cnt), 32'd0);
            if (c == 15) chk("E_stall15", 32'(stall_cnt), 32'd15);
            if (c == 19) chk("E_stall_hold", 32'(stall_cnt), 32'd15);
        end

        // Reset while draining with two cycles left (and mem_busy high).
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("F_en_rst", 32'(en_vec), 32'h0000_0003);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("F_pc_we_run", 32'(pc_we), 32'd1);
        chk("F_halted", 32'(halted), 32'd0);
        chk("F_valid", 32'({v_wb, v_mem, v_ex, v_id}), 32'd0);
        chk("F_stall", 32'(stall_cnt), 32'd0);
        chk("F_flush", 32'(flush_cnt), 32'd0);
        chk("F_retire", 32'(retire_cnt), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
